// File: rtl/ball_engine.sv
// Bouncing-ball position engine with a registered per-pixel "inside ball" test; moves once per frame_tick while in MOVE.
// Optional BALL_MISS_EN: a left/right wall contact ends the rally (back to IDLE, recentred) instead of bouncing.
module ball_engine #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int RADIUS   = 50,
  parameter int STEP     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       serve,
  input  logic       pause,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       ball,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       hit_left,
  output logic       hit_right,
  output logic       hit_top,
  output logic       hit_bottom,
  output logic [1:0] state
);

  typedef enum logic [1:0] {IDLE = 2'd0, MOVE = 2'd1, PAUSED = 2'd2} state_t;

  localparam logic [9:0]  X_CTR  = 10'(H_ACTIVE / 2);
  localparam logic [9:0]  Y_CTR  = 10'(V_ACTIVE / 2);
  localparam logic [9:0]  LO_LIM = 10'(RADIUS);
  localparam logic [9:0]  X_MAX  = 10'(H_ACTIVE - 1 - RADIUS);
  localparam logic [9:0]  Y_MAX  = 10'(V_ACTIVE - 1 - RADIUS);
  localparam logic [10:0] LO_THR = 11'(RADIUS + STEP);
  localparam logic [9:0]  STEP10 = 10'(STEP);
  localparam logic [22:0] R_SQ   = 23'(RADIUS * RADIUS);

  state_t      state_q, state_d;
  logic [9:0]  ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic        toggle_q, toggle_d;
  logic        ball_q, ball_d;
  logic        hit_l_q, hit_l_d, hit_r_q, hit_r_d, hit_t_q, hit_t_d, hit_b_q, hit_b_d;

  logic [10:0]        x_sum, y_sum;
  logic signed [10:0] dx, dy;
  logic signed [21:0] dx_ext, dy_ext;
  logic [21:0]        dx_sq, dy_sq;
  logic [22:0]        dist_sq;

  always_comb begin
    dx      = $signed({1'b0, x}) - $signed({1'b0, ball_x_q});
    dy      = $signed({1'b0, y}) - $signed({1'b0, ball_y_q});
    dx_ext  = 22'(dx);
    dy_ext  = 22'(dy);
    dx_sq   = dx_ext * dx_ext;
    dy_sq   = dy_ext * dy_ext;
    dist_sq = {1'b0, dx_sq} + {1'b0, dy_sq};
    ball_d  = (dist_sq <= R_SQ);
  end

  always_comb begin
    state_d  = state_q;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    toggle_d = toggle_q;
    hit_l_d  = 1'b0;
    hit_r_d  = 1'b0;
    hit_t_d  = 1'b0;
    hit_b_d  = 1'b0;
    x_sum    = {1'b0, ball_x_q} + 11'(STEP);
    y_sum    = {1'b0, ball_y_q} + 11'(STEP);

    case (state_q)
      IDLE: begin
        if (serve) begin
          state_d  = MOVE;
          dir_x_d  = toggle_q;
          dir_y_d  = 1'b1;
          toggle_d = ~toggle_q;
        end
      end
      MOVE: begin
        if (pause) begin
          state_d = PAUSED;
        end else if (frame_tick) begin
          // Overshoot is clamped to the wall and the direction flips in the same cycle.
          if (dir_x_q) begin
            if (x_sum > {1'b0, X_MAX}) begin
              ball_x_d = X_MAX; dir_x_d = 1'b0; hit_r_d = 1'b1;
            end else begin
              ball_x_d = x_sum[9:0];
            end
          end else if ({1'b0, ball_x_q} < LO_THR) begin
            ball_x_d = LO_LIM; dir_x_d = 1'b1; hit_l_d = 1'b1;
          end else begin
            ball_x_d = ball_x_q - STEP10;
          end

          if (dir_y_q) begin
            if (y_sum > {1'b0, Y_MAX}) begin
              ball_y_d = Y_MAX; dir_y_d = 1'b0; hit_b_d = 1'b1;
            end else begin
              ball_y_d = y_sum[9:0];
            end
          end else if ({1'b0, ball_y_q} < LO_THR) begin
            ball_y_d = LO_LIM; dir_y_d = 1'b1; hit_t_d = 1'b1;
          end else begin
            ball_y_d = ball_y_q - STEP10;
          end

`ifdef BALL_MISS_EN
          if (hit_l_d || hit_r_d) begin
            state_d  = IDLE;
            ball_x_d = X_CTR;
            ball_y_d = Y_CTR;
            dir_x_d  = dir_x_q;
          end
`else
`endif
        end
      end
      PAUSED: begin
        if (!pause) state_d = MOVE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      ball_x_q <= X_CTR;
      ball_y_q <= Y_CTR;
      dir_x_q  <= 1'b1;
      dir_y_q  <= 1'b1;
      toggle_q <= 1'b1;
      ball_q   <= 1'b0;
      hit_l_q  <= 1'b0;
      hit_r_q  <= 1'b0;
      hit_t_q  <= 1'b0;
      hit_b_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ball_x_q <= ball_x_d;
      ball_y_q <= ball_y_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      toggle_q <= toggle_d;
      ball_q   <= ball_d;
      hit_l_q  <= hit_l_d;
      hit_r_q  <= hit_r_d;
      hit_t_q  <= hit_t_d;
      hit_b_q  <= hit_b_d;
    end
  end

  assign ball       = ball_q;
  assign ball_x     = ball_x_q;
  assign ball_y     = ball_y_q;
  assign hit_left   = hit_l_q;
  assign hit_right  = hit_r_q;
  assign hit_top    = hit_t_q;
  assign hit_bottom = hit_b_q;
  assign state      = state_q;

endmodule
